// File: rtl/lin_acc_pkg.sv
// Shared types and width helpers for the multi-channel linear accumulator.
// Optional saturation build: define LIN_ACC_SAT_EN.
package lin_acc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Wide enough for K*x + C with no truncation of K*x.
    function automatic int term_w(input int wa, input int wx, input int k);
        int m;
        m = wx + $clog2(k + 1);
        if (wa > m) m = wa;
        return m + 1;
    endfunction

    localparam int TERM_W = term_w(14, 7, 2);

endpackage

// File: rtl/lin_acc_lane.sv
// One accumulator channel: a <= a + K*x + C with wrap (or saturate) and sticky ovf.
// Saturation instead of wrap when LIN_ACC_SAT_EN is defined.
module lin_acc_lane
    import lin_acc_pkg::*;
#(
    parameter int WX = 7,
    parameter int WA = 14,
    parameter int K  = 2,
    parameter int C  = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          en,
    input  logic [WX-1:0] x,
    output logic [WA-1:0] a,
    output logic          ovf
);

    localparam int TW = term_w(WA, WX, K);
    localparam int SW = TW + 1;

    logic [TW-1:0] term;
    logic [SW-1:0] sum;
    logic          hit;
    logic [WA-1:0] nxt;

    always_comb begin
        term = TW'(K) * TW'(x) + TW'(C);
        sum  = SW'(a) + SW'(term);
        hit  = |sum[SW-1:WA];
`ifdef LIN_ACC_SAT_EN
        nxt  = hit ? '1 : sum[WA-1:0];
`else
        nxt  = sum[WA-1:0];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a   <= '0;
            ovf <= 1'b0;
        end else if (clear) begin
            a   <= '0;
            ovf <= 1'b0;
        end else if (en) begin
            a <= nxt;
            if (hit) ovf <= 1'b1;
        end
    end

endmodule

// File: rtl/lin_acc_seq.sv
// Start/done controlled multi-channel linear accumulator with valid/ready input.
// Saturating lanes when LIN_ACC_SAT_EN is defined; wrapping otherwise.
module lin_acc_seq
    import lin_acc_pkg::*;
#(
    parameter int WX   = 7,
    parameter int WA   = 14,
    parameter int NCH  = 4,
    parameter int K    = 2,
    parameter int C    = 1,
    parameter int WCNT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WCNT-1:0]   len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NCH*WX-1:0] x,
    output logic [NCH*WA-1:0] a,
    output logic              busy,
    output logic              done,
    output logic [NCH-1:0]    ovf
);

    state_t          state_q;
    state_t          state_d;
    logic [WCNT-1:0] cnt_q;
    logic            clr;
    logic            beat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       cnt_q <= '0;
        else if (clr)  cnt_q <= len;
        else if (beat) cnt_q <= cnt_q - 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        clr      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    clr     = 1'b1;
                    state_d = (len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && cnt_q == WCNT'(1))
                    state_d = DONE;
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign beat = in_valid & in_ready;

    for (genvar i = 0; i < NCH; i++) begin : g_lane
        lin_acc_lane #(
            .WX(WX),
            .WA(WA),
            .K (K),
            .C (C)
        ) u_lane (
            .clk  (clk),
            .rst  (rst),
            .clear(clr),
            .en   (beat),
            .x    (x[i*WX +: WX]),
            .a    (a[i*WA +: WA]),
            .ovf  (ovf[i])
        );
    end

endmodule

// File: tb/tb_lin_acc_seq.sv
// Self-checking bench for lin_acc_seq: directed plan plus randomized runs
// against an arithmetic reference model.
module tb_lin_acc_seq;

    localparam int WX   = 7;
    localparam int WA   = 14;
    localparam int NCH  = 4;
    localparam int K    = 2;
    localparam int C    = 1;
    localparam int WCNT = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [WCNT-1:0]   len;
    logic              in_valid;
    logic              in_ready;
    logic [NCH*WX-1:0] x;
    logic [NCH*WA-1:0] a;
    logic              busy;
    logic              done;
    logic [NCH-1:0]    ovf;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    longint mdl_a[NCH];
    bit     mdl_ovf[NCH];

    lin_acc_seq #(
        .WX(WX), .WA(WA), .NCH(NCH),
        .K(K), .C(C), .WCNT(WCNT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .x(x),
        .a(a), .busy(busy), .done(done), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, longint obs, longint exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_lanes(string tag);
        logic [NCH-1:0] eo;
        for (int i = 0; i < NCH; i++) begin
            chk($sformatf("%s.a%0d", tag, i),
                longint'(a[i*WA +: WA]), mdl_a[i]);
            eo[i] = mdl_ovf[i];
        end
        chk({tag, ".ovf"}, longint'(ovf), longint'(eo));
    endtask

    task automatic chk_ctl(string tag, bit r, bit b, bit d);
        chk({tag, ".rdy"}, longint'(in_ready), longint'(r));
        chk({tag, ".busy"}, longint'(busy), longint'(b));
        chk({tag, ".done"}, longint'(done), longint'(d));
    endtask

    task automatic mdl_clear();
        for (int i = 0; i < NCH; i++) begin
            mdl_a[i]   = 0;
            mdl_ovf[i] = 0;
        end
    endtask

    task automatic mdl_beat(logic [NCH*WX-1:0] xv);
        longint s;
        longint lim;
        lim = longint'(1) << WA;
        for (int i = 0; i < NCH; i++) begin
            s = mdl_a[i] + K * longint'(xv[i*WX +: WX]) + C;
            if (s >= lim) begin
                mdl_ovf[i] = 1;
`ifdef LIN_ACC_SAT_EN
                s = lim - 1;
`else
                s = s % lim;
`endif
            end
            mdl_a[i] = s;
        end
    endtask

    task automatic go(int n);
        start = 1'b1;
        len   = WCNT'(n);
        tick();
        start = 1'b0;
        mdl_clear();
    endtask

    task automatic beat(logic [NCH*WX-1:0] xv);
        in_valid = 1'b1;
        x        = xv;
        tick();
        in_valid = 1'b0;
        mdl_beat(xv);
    endtask

    function automatic logic [NCH*WX-1:0] all_x(int v);
        logic [NCH*WX-1:0] r;
        for (int i = 0; i < NCH; i++) r[i*WX +: WX] = WX'(v);
        return r;
    endfunction

    initial begin
        logic [NCH*WX-1:0] xv;
        int n;
        rst      = 1'b1;
        start    = 1'b0;
        len      = '0;
        in_valid = 1'b0;
        x        = '0;
        mdl_clear();
        tick();
        chk_lanes("reset");
        chk_ctl("reset", 0, 0, 0);
        rst = 1'b0;
        tick();

        // plan 1: len=3, x=1 -> 9
        go(3);
        chk_ctl("p1.run", 1, 1, 0);
        for (int b = 0; b < 3; b++) begin
            beat(all_x(1));
            chk_lanes($sformatf("p1.b%0d", b));
        end
        chk({"p1.a0"}, longint'(a[WA-1:0]), 9);
        chk_ctl("p1.done", 0, 1, 1);
        tick();
        chk_ctl("p1.idle", 0, 0, 0);
        chk_lanes("p1.hold");

        // plan 2: square sequence on lane 0
        go(4);
        for (int b = 0; b < 4; b++) begin
            xv = '0;
            xv[WX-1:0] = WX'(b);
            beat(xv);
            chk("p2.sq", longint'(a[WA-1:0]), longint'((b + 1) * (b + 1)));
            chk_lanes($sformatf("p2.b%0d", b));
        end
        chk_ctl("p2.done", 0, 1, 1);
        tick();

        // plan 3: overflow
        go(65);
        for (int b = 0; b < 65; b++) beat(all_x(127));
`ifdef LIN_ACC_SAT_EN
        chk("p3.sat", longint'(a[WA-1:0]), 16383);
`else
        chk("p3.wrap", longint'(a[WA-1:0]), 191);
`endif
        chk("p3.ovf", longint'(ovf), 4'hf);
        chk_lanes("p3");
        chk_ctl("p3.done", 0, 1, 1);
        tick();

        // plan 4: stall
        go(2);
        beat(all_x(1));
        for (int g = 0; g < 3; g++) begin
            tick();
            chk_lanes($sformatf("p4.gap%0d", g));
            chk_ctl("p4.gap", 1, 1, 0);
        end
        beat(all_x(1));
        chk("p4.a", longint'(a[WA-1:0]), 6);
        chk_ctl("p4.done", 0, 1, 1);
        tick();

        // plan 5: len=0, then ignored start during run
        go(0);
        chk_ctl("p5.z", 0, 1, 1);
        chk_lanes("p5.z");
        tick();
        chk_ctl("p5.zi", 0, 0, 0);
        go(3);
        beat(all_x(2));
        start = 1'b1;
        len   = WCNT'(1);
        tick();
        start = 1'b0;
        chk_ctl("p5.ign", 1, 1, 0);
        chk_lanes("p5.ign");
        beat(all_x(2));
        chk_ctl("p5.mid", 1, 1, 0);
        beat(all_x(2));
        chk_lanes("p5.end");
        chk_ctl("p5.done", 0, 1, 1);
        tick();

        // plan 6: async reset mid-run
        go(5);
        beat(all_x(3));
        beat(all_x(3));
        rst = 1'b1;
        #1;
        mdl_clear();
        chk_lanes("p6.rst");
        chk_ctl("p6.rst", 0, 0, 0);
        tick();
        rst = 1'b0;
        tick();
        go(1);
        beat(all_x(2));
        chk("p6.a", longint'(a[WA-1:0]), 5);
        chk_ctl("p6.done", 0, 1, 1);
        tick();

        // randomized runs with random stalls
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 12);
            go(n);
            for (int b = 0; b < n; b++) begin
                while ($urandom_range(0, 3) == 0) begin
                    tick();
                    chk_ctl("rnd.stall", 1, 1, 0);
                end
                for (int i = 0; i < NCH; i++)
                    xv[i*WX +: WX] = WX'($urandom);
                beat(xv);
                chk_lanes($sformatf("rnd%0d.b%0d", r, b));
            end
            chk_ctl("rnd.done", 0, 1, 1);
            tick();
            chk_ctl("rnd.idle", 0, 0, 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/lin_acc_seq.md
Name: lin_acc_seq

Overview:
Multi-channel sequential linear accumulator. Per channel, each accepted sample updates a <= a + K*x + C (defaults K=2, C=1 give the odd-number/square sequence). A start/done controller runs a programmable number of samples under a valid/ready handshake. Wrap-around overflow is flagged per channel. Sits between a sample source and any consumer of per-channel running sums.

Parameters:
WX, 7, sample width per channel (unsigned)
WA, 14, accumulator width per channel
NCH, 4, number of channels
K, 2, multiplier applied to x (unsigned constant, >=1)
C, 1, additive constant per beat (unsigned, < 2^WA)
WCNT, 8, width of sample-count register

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  begin a run; sampled only in IDLE
len  in  WCNT  number of samples in the run; captured on start
in_valid  in  1  sample beat valid
in_ready  out  1  block accepts a beat
x  in  NCH*WX  packed samples; channel i at bits [i*WX +: WX]
a  out  NCH*WA  packed accumulators; channel i at bits [i*WA +: WA]
busy  out  1  high in RUN and DONE
done  out  1  one-cycle pulse at end of run
ovf  out  NCH  sticky per-channel overflow flag

Behaviour:
- Interface: reset rst, asynchronous, active-high; clock clk.
- Reset: state=IDLE; a=0; ovf=0; done=0; busy=0; in_ready=0; counter=0. Reset asserted mid-run aborts the run immediately (asynchronously). No partial result is kept.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=0. On start=1: capture len into counter, clear all a and ovf to 0.
  - len!=0: go to RUN.
  - len==0: go to DONE.
- RUN: in_ready=1. A beat is accepted when in_valid && in_ready. On a beat, every channel updates a_i <= a_i + K*x_i + C on that edge, and the counter decrements.
  - When the beat that takes the counter from 1 to 0 is accepted, go to DONE.
  - in_valid=0 stalls: no change.
  - start is ignored in RUN.
- DONE: done=1 for exactly one cycle, in_ready=0, then IDLE. start is ignored in DONE.
- a holds its final value in IDLE until the next accepted start.
- Latency: a reflects a beat one clock after the acceptance edge. done is high in the cycle after the last accepted beat.
- Arithmetic:
  - term = K*x + C, computed at width WA+1 or wider, with no truncation of K*x.
  - sum = a + term, computed at WA+1 bits; result = sum mod 2^WA (wrap).
  - ovf_i is set when sum >= 2^WA and stays set until the next start or reset.
- len captured at WCNT bits; maximum run is 2^WCNT-1 beats.

Optional Feature:
Macro LIN_ACC_SAT_EN.
- Defined: on overflow, a_i saturates to 2^WA-1 and stays there for later beats of the run; ovf_i is still set.
- Undefined: wrap modulo 2^WA as above.

Decomposition:
- Package lin_acc_pkg: state typedef (IDLE, RUN, DONE); localparam term width = max(WA, WX+clog2(K+1)) + 1.
- One sub-module per channel: lin_acc_lane (holds one accumulator; inputs clear, en, x; outputs a, ovf; contains the wrap/saturate logic).
- The top level holds the FSM and counter, and generates NCH lanes.

Test Plan:
1. Defaults; start with len=3; x=1 on all lanes for 3 back-to-back beats -> a=9 on every lane; done pulses in the cycle after the 3rd beat; ovf=0.
2. len=4; lane0 x=0,1,2,3 -> lane0 a=1,4,9,16 after each beat (square sequence); other lanes x=0 -> a=4.
3. len=65; x=127 every beat -> wrap build: a=191 and ovf=1. With LIN_ACC_SAT_EN: a=16383 and ovf=1.
4. len=2 with in_valid low for 3 cycles between beats -> a and counter unchanged during the gap; in_ready stays high; final a=6 for x=1.
5. len=0 -> DONE the cycle after start; done pulses once; a=0; in_ready never rises. A start pulse during RUN of a len=3 run is ignored.
6. Assert rst after the 2nd beat of a len=5 run -> a=0, ovf=0, in_ready=0, busy=0 immediately. A subsequent start with len=1, x=2 -> a=5.
